// File: rtl/add_rr_scheduler_if.sv
// Request/response bundle between NUM_REQ requesters, the shared adder scheduler and
// the downstream consumer. The scheduler takes the slave side.
interface add_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_c;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c
  );
endinterface

// File: rtl/add_rr_scheduler.sv
// Round-robin scheduler sharing one 2-stage pipelined adder among NUM_REQ requesters;
// results return tagged with the requester index, in grant order.
module add_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input logic clk,
  input logic rst,
  add_rr_scheduler_if.slave io_bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]   r_p0_a;
  logic [WIDTH-1:0]   r_p0_b;
  logic [ID_W-1:0]    r_p0_id;
  logic               r_p0_valid;
  logic [WIDTH-1:0]   r_p1_c;
  logic [ID_W-1:0]    r_p1_id;
  logic               r_p1_valid;

  logic               w_en0;
  logic               w_en1;
  logic [ID_W-1:0]    w_gnt;
  logic               w_found;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [ID_W-1:0]    w_next_ptr;

  assign w_en1 = !r_p1_valid || io_bus.rsp_ready;
  assign w_en0 = !r_p0_valid || w_en1;

  // Scan from farthest to nearest offset so the requester closest to r_rr_ptr wins.
  always_comb begin
    int idx;
    w_gnt   = '0;
    w_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (io_bus.req_valid[idx]) begin
        w_gnt   = idx[ID_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_sel_a = io_bus.req_a[i*WIDTH +: WIDTH];
        w_sel_b = io_bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ready    = (w_found && w_en0 && !rst) ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_xfer     = |(w_ready & io_bus.req_valid);
  assign w_next_ptr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);

  assign io_bus.req_ready = w_ready;
  assign io_bus.rsp_valid = r_p1_valid;
  assign io_bus.rsp_id    = r_p1_id;
  assign io_bus.rsp_c     = r_p1_c;

  // A stalled stage 1 freezes stage 0 too, since w_en0 then requires p0 to be empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_p0_a     <= '0;
      r_p0_b     <= '0;
      r_p0_id    <= '0;
      r_p0_valid <= 1'b0;
      r_p1_c     <= '0;
      r_p1_id    <= '0;
      r_p1_valid <= 1'b0;
    end else begin
      if (w_en1) begin
        r_p1_c     <= r_p0_a + r_p0_b;
        r_p1_id    <= r_p0_id;
        r_p1_valid <= r_p0_valid;
      end
      if (w_xfer) begin
        r_p0_a     <= w_sel_a;
        r_p0_b     <= w_sel_b;
        r_p0_id    <= w_gnt;
        r_p0_valid <= 1'b1;
        r_rr_ptr   <= w_next_ptr;
      end else if (w_en0) begin
        r_p0_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_add_rr_scheduler.sv
// Directed bench for add_rr_scheduler: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares every retired response.
module tb_add_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus();

  add_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [ID_W+WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] opA[NUM_REQ];
  logic [WIDTH-1:0] opB[NUM_REQ];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setOp(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opA[i] = a;
    opB[i] = b;
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Drive one cycle of requests, check the grant, and record what the grant will return.
  task automatic applyStimulus(input string name, input logic [NUM_REQ-1:0] valid,
                               input logic rspRdy, input logic [NUM_REQ-1:0] expReady);
    @(posedge clk);
    #1;
    bus.req_valid = valid;
    bus.rsp_ready = rspRdy;
    @(negedge clk);
    checkOutput(name, 64'(bus.req_ready), 64'(expReady));
    for (int i = 0; i < NUM_REQ; i++)
      if (expReady[i]) expQ.push_back({ID_W'(i), opA[i] + opB[i]});
  endtask

  // Monitor: retire responses against the queue and check hold-stability under backpressure.
  initial begin
    logic             holdPrev;
    logic [ID_W-1:0]  prevId;
    logic [WIDTH-1:0] prevC;
    logic [ID_W+WIDTH-1:0] exp;
    holdPrev = 1'b0;
    prevId   = '0;
    prevC    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holdPrev = 1'b0;
      end else begin
        if (holdPrev) begin
          checkOutput("rsp_stable_id", 64'(bus.rsp_id), 64'(prevId));
          checkOutput("rsp_stable_c", 64'(bus.rsp_c), 64'(prevC));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_unexpected actual id=%0d c=%0h required none", bus.rsp_id, bus.rsp_c);
          end else begin
            exp = expQ.pop_front();
            checkOutput("rsp_id", 64'(bus.rsp_id), 64'(exp[ID_W+WIDTH-1:WIDTH]));
            checkOutput("rsp_c", 64'(bus.rsp_c), 64'(exp[WIDTH-1:0]));
          end
        end
        holdPrev = bus.rsp_valid && !bus.rsp_ready;
        prevId   = bus.rsp_id;
        prevC    = bus.rsp_c;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) setOp(i, '0, '0);

    // Reset state, with all requesters pushing to prove req_ready is masked.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '1;
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    checkOutput("rst_rsp_c", 64'(bus.rsp_c), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;

    $display("[TB] T1 single request");
    setOp(0, 32'd3, 32'd4);
    applyStimulus("t1_grant", 4'b0001, 1'b1, 4'b0001);
    applyStimulus("t1_idle0", 4'b0000, 1'b1, 4'b0000);
    checkOutput("t1_not_yet", 64'(bus.rsp_valid), 64'(0));
    applyStimulus("t1_idle1", 4'b0000, 1'b1, 4'b0000);
    checkOutput("t1_latency", 64'(bus.rsp_valid), 64'(1));

    $display("[TB] T2 all valid");
    setOp(1, 32'd10, 32'd20);
    setOp(2, 32'h1234_0000, 32'h0000_5678);
    setOp(3, 32'd100, 32'd1);
    applyStimulus("t2_setup_id3", 4'b1000, 1'b1, 4'b1000);
    for (int k = 0; k < 5; k++)
      applyStimulus($sformatf("t2_grant%0d", k), 4'b1111, 1'b1, 4'(1 << (k % 4)));

    $display("[TB] T3 rotation");
    setOp(2, 32'd7, 32'd8);
    applyStimulus("t3_id2", 4'b0100, 1'b1, 4'b0100);
    setOp(0, 32'd50, 32'd60);
    applyStimulus("t3_id0", 4'b0101, 1'b1, 4'b0001);
    applyStimulus("t3_id2b", 4'b0101, 1'b1, 4'b0100);
    applyStimulus("t3_drain0", 4'b0000, 1'b1, 4'b0000);
    applyStimulus("t3_drain1", 4'b0000, 1'b1, 4'b0000);

    $display("[TB] T4 backpressure");
    setOp(0, 32'hAAAA_0000, 32'h0000_5555);
    setOp(1, 32'd11, 32'd22);
    setOp(2, 32'd1000, 32'd2000);
    applyStimulus("t4_acc0", 4'b0001, 1'b0, 4'b0001);
    applyStimulus("t4_acc1", 4'b0010, 1'b0, 4'b0010);
    for (int k = 0; k < 5; k++)
      applyStimulus($sformatf("t4_stall%0d", k), 4'b0100, 1'b0, 4'b0000);
    checkOutput("t4_held_valid", 64'(bus.rsp_valid), 64'(1));
    applyStimulus("t4_release", 4'b0100, 1'b1, 4'b0100);
    for (int k = 0; k < 3; k++)
      applyStimulus($sformatf("t4_drain%0d", k), 4'b0000, 1'b1, 4'b0000);

    $display("[TB] T5 overflow");
    setOp(0, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus("t5_ovf0", 4'b0001, 1'b1, 4'b0001);
    setOp(1, 32'h8000_0000, 32'h8000_0000);
    applyStimulus("t5_ovf1", 4'b0010, 1'b1, 4'b0010);
    applyStimulus("t5_drain0", 4'b0000, 1'b1, 4'b0000);
    checkOutput("t5_zero_a", 64'(bus.rsp_c), 64'(0));
    applyStimulus("t5_drain1", 4'b0000, 1'b1, 4'b0000);
    checkOutput("t5_zero_b", 64'(bus.rsp_c), 64'(0));
    applyStimulus("t5_drain2", 4'b0000, 1'b1, 4'b0000);

    $display("[TB] T6 reset mid-operation");
    setOp(0, 32'd5, 32'd6);
    setOp(1, 32'd9, 32'd9);
    setOp(2, 32'd40, 32'd2);
    applyStimulus("t6_acc0", 4'b0001, 1'b0, 4'b0001);
    applyStimulus("t6_acc1", 4'b0010, 1'b0, 4'b0010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("t6_ready_in_rst", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_rsp_flushed", 64'(bus.rsp_valid), 64'(0));
    checkOutput("t6_first_grant", 64'(bus.req_ready), 64'(4'b0010));
    expQ.push_back({ID_W'(1), opA[1] + opB[1]});
    applyStimulus("t6_second_grant", 4'b0110, 1'b1, 4'b0100);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      applyStimulus("final_idle", 4'b0000, 1'b1, 4'b0000);
      waitCycles++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
    applyStimulus("final_quiet", 4'b0000, 1'b1, 4'b0000);
    checkOutput("final_rsp_valid", 64'(bus.rsp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
